pipe_mem_arbiter: RTL and testbench

//   Shares one unified single-port memory between the PipelineCPU fetch stage (I port)
//   and its memory stage (D port). Each access is a level req / valid handshake; the

---
 rtl/pipe_mem_arbiter.sv | 117 +++++++++++
 tb/tb_pipe_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - fetch/data arbiter onto one single-port memory with D priority and starvation cap
module pipe_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          d_elig, i_elig, starved;
    logic          grant_d, grant_i;

    // A port in its valid cycle is not eligible, so a held req is not re-granted twice.
    assign d_elig  = d_req & ~d_valid;
    assign i_elig  = if_req & ~if_valid;
    assign starved = (starve_cnt == CW'(STARVE_MAX));

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_elig && !(i_elig && starved)) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end else if (i_elig) begin
                    grant_i   = 1'b1;
                    state_nxt = IACC;
                end
            end
            DACC, IACC: begin
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                if (!if_req)      starve_cnt <= '0;
                else if (!starved) starve_cnt <= starve_cnt + CW'(1);
            end
            if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                starve_cnt <= '0;
            end
            if (state != IDLE && mem_ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == DACC) begin
                    d_valid <= 1'b1;
                    if (!mem_we) d_rdata <= mem_rdata;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - directed checks of pipe_mem_arbiter against hand-computed expectations
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we, busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] rdata_val = 32'h0;

    pipe_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory responder: acks ack_delay cycles after the first cycle mem_req is seen.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = (wait_cnt == ack_delay);
            mem_rdata = rdata_val;
            wait_cnt  = mem_ack ? 0 : wait_cnt + 1;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_order [0:5];
    int          g;
    logic        prev_req;

    initial begin
        reset = 1'b0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        tick; tick;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst_busy_stall", {29'd0, busy, if_stall, d_stall}, 32'd0);
        reset = 1'b1;
        tick;

        // Fetch with immediate ack
        rdata_val = 32'hDEADBEEF;
        if_addr = 32'h10; if_req = 1'b1;
        #1;
        chk("f_c0_stall", {31'd0, if_stall}, 32'd1);
        chk("f_c0_mem_req", {31'd0, mem_req}, 32'd0);
        tick;
        chk("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_c1_mem_addr", mem_addr, 32'h10);
        chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_c1_stall_busy", {30'd0, if_stall, busy}, 32'd3);
        tick;
        chk("f_c2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("f_c2_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_c2_mem_req", {31'd0, mem_req}, 32'd0);
        chk("f_c2_stall", {31'd0, if_stall}, 32'd0);
        if_req = 1'b0;
        tick;
        chk("f_c3_if_valid", {31'd0, if_valid}, 32'd0);
        chk("f_c3_if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Simultaneous fetch and load: D first
        rdata_val = 32'hA5A50080;
        if_addr = 32'h20; if_req = 1'b1;
        d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
        tick;
        chk("pr_c1_mem_addr", mem_addr, 32'h80);
        chk("pr_c1_if_stall", {31'd0, if_stall}, 32'd1);
        tick;
        chk("pr_c2_d_valid", {31'd0, d_valid}, 32'd1);
        chk("pr_c2_d_rdata", d_rdata, 32'hA5A50080);
        chk("pr_c2_if_stall", {31'd0, if_stall}, 32'd1);
        d_req = 1'b0;
        rdata_val = 32'h11110020;
        tick;
        chk("pr_c3_mem_addr", mem_addr, 32'h20);
        chk("pr_c3_mem_req", {31'd0, mem_req}, 32'd1);
        chk("pr_c3_if_stall", {31'd0, if_stall}, 32'd1);
        tick;
        chk("pr_c4_if_valid", {31'd0, if_valid}, 32'd1);
        chk("pr_c4_if_rdata", if_rdata, 32'h11110020);
        chk("pr_c4_d_valid", {31'd0, d_valid}, 32'd0);
        if_req = 1'b0;
        tick;

        // Store leaves d_rdata alone
        rdata_val = 32'hFFFFFFFF;
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; d_req = 1'b1;
        tick;
        chk("st_c1_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_c1_mem_addr", mem_addr, 32'h40);
        chk("st_c1_mem_wdata", mem_wdata, 32'h1234);
        tick;
        chk("st_c2_d_valid", {31'd0, d_valid}, 32'd1);
        chk("st_c2_d_rdata", d_rdata, 32'hA5A50080);
        chk("st_c2_mem_we", {31'd0, mem_we}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick;
        chk("st_c3_d_valid", {31'd0, d_valid}, 32'd0);

        // Load with ack delayed 5 cycles
        ack_delay = 5;
        rdata_val = 32'hCAFE0090;
        d_addr = 32'h90; d_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("ld5_c%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("ld5_c%0d_mem_addr", k), mem_addr, 32'h90);
            chk($sformatf("ld5_c%0d_stall_valid", k), {30'd0, d_stall, d_valid}, 32'd2);
        end
        tick;
        chk("ld5_c7_d_valid", {31'd0, d_valid}, 32'd1);
        chk("ld5_c7_d_rdata", d_rdata, 32'hCAFE0090);
        chk("ld5_c7_d_stall", {31'd0, d_stall}, 32'd0);
        d_req = 1'b0;
        ack_delay = 0;
        tick;

        // Starvation cap; fetch req is withdrawn in each d_valid cycle so D can win back-to-back
        exp_order[0] = 32'hC0; exp_order[1] = 32'hC0; exp_order[2] = 32'hC0;
        exp_order[3] = 32'hC0; exp_order[4] = 32'h30; exp_order[5] = 32'hC0;
        rdata_val = 32'h0;
        g = 0; prev_req = 1'b0;
        d_addr = 32'hC0; d_we = 1'b0; d_req = 1'b1;
        if_addr = 32'h30; if_req = 1'b1;
        for (int k = 0; k < 80 && g < 6; k++) begin
            tick;
            if (mem_req && !prev_req) begin
                chk($sformatf("sv_grant%0d_addr", g), mem_addr, exp_order[g]);
                g++;
            end
            prev_req = mem_req;
            if_req = d_valid ? 1'b0 : 1'b1;
        end
        chk("sv_grant_count", 32'(g), 32'd6);
        if_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (d_valid) break;
        end
        chk("sv_drain_d_valid", {31'd0, d_valid}, 32'd1);
        d_req = 1'b0;
        tick;

        // Reset in the middle of a D access
        ack_delay = 5;
        rdata_val = 32'h5A5A0050;
        d_addr = 32'h50; d_req = 1'b1;
        tick;
        chk("rs_c1_mem_req", {31'd0, mem_req}, 32'd1);
        tick;
        reset = 1'b0;
        #1;
        chk("rs_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rs_async_busy", {31'd0, busy}, 32'd0);
        chk("rs_async_d_rdata", d_rdata, 32'd0);
        ack_delay = 0;
        tick;
        chk("rs_hold_d_valid", {31'd0, d_valid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rs_r0_d_valid_busy", {30'd0, d_valid, busy}, 32'd0);
        tick;
        chk("rs_r1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rs_r1_mem_addr", mem_addr, 32'h50);
        chk("rs_r1_d_valid", {31'd0, d_valid}, 32'd0);
        tick;
        chk("rs_r2_d_valid", {31'd0, d_valid}, 32'd1);
        chk("rs_r2_d_rdata", d_rdata, 32'h5A5A0050);
        d_req = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
